// File: rtl/and_response_checker_pkg.sv
// Shared types for the AND-gate response checker: FSM state encoding and
// the payload carried through the expected-value delay line.
package and_response_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic vld;
    logic exp;
  } line_t;

  localparam int unsigned LINE_W = $bits(line_t);

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift line; the top uses one bit as a valid flag.
// DEPTH==0 degenerates to a wire.
module valid_delay_line #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ok;
      assign unused_ok = ^{clk, rst_n, clr};
      assign out       = in;
    end else begin : g_line
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
        if (!clr) begin
          stage_d[0] = in;
          for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
        end
      end

      // NOTE: every stage is reset, not just the head -- a stale valid bit
      // left in the line after reset would be counted as a compare.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign out = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/and_response_checker.sv
// Receive-side monitor for an AND-gate DUT: delays a&b by the DUT latency,
// compares against dut_out, and reports counts, first failure and pass/done.
module and_response_checker
  import and_response_checker_pkg::*;
#(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned NUM_VECTORS = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stim_valid,
  input  logic             stim_a,
  input  logic             stim_b,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_fail_vld,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_exp
);

  localparam logic [CNT_W-1:0] NUM_V   = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic             ffv_q, ffv_d;
  logic             ffe_q, ffe_d;
  logic             pass_q, pass_d;

  logic  line_clr;
  logic  push;
  logic  cmp;
  logic  mismatch;
  line_t line_in;
  line_t line_out;

  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign push     = (state_q == ST_RUN) && stim_valid;
  assign line_in  = '{vld: push, exp: stim_a & stim_b};
  assign cmp      = line_out.vld && busy;
  assign mismatch = cmp && (dut_out != line_out.exp);

  valid_delay_line #(
    .WIDTH (LINE_W),
    .DEPTH (LATENCY)
  ) u_line (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (line_clr),
    .in    (line_in),
    .out   (line_out)
  );

  // NOTE: every output of this block gets a default first; a path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    vec_d    = vec_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffi_d    = ffi_q;
    ffe_d    = ffe_q;
    pass_d   = pass_q;
    line_clr = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_RUN;
          acc_d    = '0;
          vec_d    = '0;
          err_d    = '0;
          ffv_d    = 1'b0;
          ffi_d    = '0;
          ffe_d    = 1'b0;
          pass_d   = 1'b0;
          line_clr = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (push) acc_d = acc_q + ONE;
        if (cmp)  vec_d = vec_q + ONE;
        if (mismatch) begin
          if (err_q != CNT_MAX) err_d = err_q + ONE;
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = vec_q;
            ffe_d = line_out.exp;
          end
        end
        // Each accepted vector is compared exactly once, so the last compare
        // also means the line is empty; with LATENCY=0 this fires from RUN.
        if (cmp && (vec_d == NUM_V)) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end else if ((state_q == ST_RUN) && (acc_d == NUM_V)) begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
      ffe_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
      ffe_q   <= ffe_d;
      pass_q  <= pass_d;
    end
  end

  assign done           = (state_q == ST_DONE);
  assign pass           = pass_q;
  assign vec_count      = vec_q;
  assign err_count      = err_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_exp = ffe_q;

endmodule

// File: tb/tb_and_response_checker.sv
// Bench for and_response_checker: a LATENCY=2 instance checked every cycle
// against a queue-based model, plus a LATENCY=0 instance checked directly.
module tb_and_response_checker;

  localparam int LAT = 2;
  localparam int NV  = 4;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start0 = 1'b0;
  logic stim_valid = 1'b0;
  logic stim_a = 1'b0;
  logic stim_b = 1'b0;
  logic dut_out, dut_out0;

  logic          busy, done, pass, ffv, ffe;
  logic [CW-1:0] vec_count, err_count, ffi;
  logic          busy0, done0, pass0, ffv0, ffe0;
  logic [CW-1:0] vec_count0, err_count0, ffi0;

  always #5 clk = ~clk;

  and_response_checker #(.LATENCY(LAT), .NUM_VECTORS(NV), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stim_valid(stim_valid),
    .stim_a(stim_a), .stim_b(stim_b), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .vec_count(vec_count),
    .err_count(err_count), .first_fail_vld(ffv), .first_fail_idx(ffi),
    .first_fail_exp(ffe)
  );

  and_response_checker #(.LATENCY(0), .NUM_VECTORS(NV), .CNT_W(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .stim_valid(stim_valid),
    .stim_a(stim_a), .stim_b(stim_b), .dut_out(dut_out0),
    .busy(busy0), .done(done0), .pass(pass0), .vec_count(vec_count0),
    .err_count(err_count0), .first_fail_vld(ffv0), .first_fail_idx(ffi0),
    .first_fail_exp(ffe0)
  );

  // Emulated gate under test: two register stages, then AND / stuck-0 / OR.
  int         dut_mode = 0;
  logic [1:0] p1 = 2'b00;
  logic [1:0] p2 = 2'b00;
  always @(posedge clk) begin
    p1 <= {stim_a, stim_b};
    p2 <= p1;
  end
  assign dut_out  = (dut_mode == 0) ? (p2[1] & p2[0]) :
                    (dut_mode == 1) ? 1'b0 : (p2[1] | p2[0]);
  assign dut_out0 = stim_a & stim_b;

  int n_pass  = 0;
  int n_total = 0;
  bit sim_end = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: a queue of expected bits, each due LAT edges after acceptance.
  typedef struct {
    int due;
    bit exp;
  } pend_t;

  pend_t q[$];
  int    cyc = 0;
  bit    m_run = 0, m_done = 0, m_pass = 0, m_ffv = 0, m_ffe = 0;
  int    m_acc = 0, m_vec = 0, m_err = 0, m_ffi = 0;

  always @(posedge clk) begin
    pend_t e;
    pend_t n;
    cyc++;
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_pass = 0; m_ffv = 0; m_ffe = 0;
      m_acc = 0; m_vec = 0; m_err = 0; m_ffi = 0;
      q.delete();
    end else if (m_run) begin
      if (stim_valid && m_acc < NV) begin
        n.due = cyc + LAT;
        n.exp = stim_a & stim_b;
        q.push_back(n);
        m_acc++;
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        if (dut_out !== 1'(e.exp)) begin
          if (m_err < 255) m_err++;
          if (!m_ffv) begin
            m_ffv = 1; m_ffi = m_vec; m_ffe = e.exp;
          end
        end
        m_vec++;
      end
      if (m_vec == NV) begin
        m_run = 0; m_done = 1; m_pass = (m_err == 0);
      end
    end else if (start) begin
      m_run = 1; m_done = 0; m_pass = 0; m_ffv = 0; m_ffe = 0;
      m_acc = 0; m_vec = 0; m_err = 0; m_ffi = 0;
      q.delete();
    end
  end

  always @(posedge clk) begin
    #1;
    if (!sim_end) begin
      check("cyc_busy",      busy,      m_run);
      check("cyc_done",      done,      m_done);
      check("cyc_pass",      pass,      m_pass);
      check("cyc_vec_count", vec_count, m_vec);
      check("cyc_err_count", err_count, m_err);
      check("cyc_ff_vld",    ffv,       m_ffv);
      check("cyc_ff_idx",    ffi,       m_ffi);
      check("cyc_ff_exp",    ffe,       m_ffe);
    end
  end

  task automatic drive(input bit st, input bit v, input bit a, input bit b);
    @(negedge clk);
    start = st; stim_valid = v; stim_a = a; stim_b = b;
  endtask

  task automatic begin_run;
    drive(1, 0, 0, 0);
  endtask

  task automatic send(input bit a, input bit b);
    drive(0, 1, a, b);
  endtask

  task automatic bubble;
    drive(0, 0, 0, 0);
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #2;
      seen = done;
    end
    check(name, seen, 1);
  endtask

  task automatic four_vectors;
    begin_run;
    send(0, 0); send(1, 0); send(1, 1); send(0, 1);
    bubble;
    wait_done("run_done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_vec",  vec_count, 0);
    rst_n = 1'b1;

    // 1: true AND
    dut_mode = 0;
    four_vectors;
    check("t1_vec",  vec_count, 4);
    check("t1_err",  err_count, 0);
    check("t1_pass", pass, 1);
    check("t1_ffv",  ffv, 0);

    // 2: stuck-at-0 misses only vector 11
    dut_mode = 1;
    four_vectors;
    check("t2_err",  err_count, 1);
    check("t2_ffi",  ffi, 2);
    check("t2_ffe",  ffe, 1);
    check("t2_pass", pass, 0);
    check("t2_ffv",  ffv, 1);

    // 3: OR differs on 10 and 01
    dut_mode = 2;
    four_vectors;
    check("t3_err",  err_count, 2);
    check("t3_ffi",  ffi, 1);
    check("t3_ffe",  ffe, 0);
    check("t3_vec",  vec_count, 4);

    // 4: bubbles 1,0,0,1,1,0,1
    dut_mode = 0;
    begin_run;
    send(1, 1); bubble; bubble; send(0, 1); send(1, 1); bubble; send(1, 0);
    @(posedge clk); #1;
    check("t4_done_e0", done, 0);
    bubble;
    @(posedge clk); #1;
    check("t4_done_e1", done, 0);
    @(posedge clk); #1;
    check("t4_done_e2", done, 1);
    check("t4_vec",  vec_count, 4);
    check("t4_err",  err_count, 0);
    check("t4_pass", pass, 1);

    // 5: reset mid-run, then a clean run
    begin_run;
    send(1, 1); send(1, 0); bubble; bubble;
    check("t5_busy_pre", busy, 1);
    check("t5_vec_pre",  vec_count, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_pass", pass, 0);
    check("t5_vec",  vec_count, 0);
    check("t5_err",  err_count, 0);
    check("t5_ffv",  ffv, 0);
    check("t5_ffi",  ffi, 0);
    check("t5_ffe",  ffe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    four_vectors;
    check("t5_clean_vec",  vec_count, 4);
    check("t5_clean_pass", pass, 1);

    // 6: LATENCY=0 instance; start in RUN and stim in DONE are ignored
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0; stim_valid = 1; stim_a = 1; stim_b = 1;
    @(negedge clk); start0 = 1'b1; stim_a = 1; stim_b = 0;
    @(posedge clk); #1;
    check("t6_vec_mid",  vec_count0, 2);
    check("t6_busy_mid", busy0, 1);
    @(negedge clk); start0 = 1'b0; stim_a = 1; stim_b = 1;
    @(negedge clk); stim_a = 0; stim_b = 1;
    @(posedge clk); #1;
    check("t6_done",  done0, 1);
    check("t6_busy",  busy0, 0);
    check("t6_vec",   vec_count0, 4);
    check("t6_err",   err_count0, 0);
    check("t6_pass",  pass0, 1);
    @(negedge clk); stim_a = 1; stim_b = 1;
    @(posedge clk); #1;
    check("t6_vec_in_done", vec_count0, 4);
    check("t6_done_hold",   done0, 1);
    @(negedge clk); stim_valid = 0; start0 = 1'b1;
    @(posedge clk); #1;
    check("t6_restart_vec",  vec_count0, 0);
    check("t6_restart_done", done0, 0);
    check("t6_restart_busy", busy0, 1);
    @(negedge clk); start0 = 1'b0;

    repeat (2) @(negedge clk);
    sim_end = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
